// File: rtl/risc_v_fetch_stage.sv
// Instruction fetch stage: owns the word PC, issues reads to a 1-cycle
// synchronous instruction memory, buffers responses in a small FIFO and
// presents them to decode over a valid/ready handshake.
//
// Handshake: an instruction transfers in a cycle where instr_valid_o and
// instr_ready_i are both high. Once valid is high, instr_o, pc_o and
// illegal_o hold steady until that transfer or a redirect. A redirect
// forces valid low in its own cycle, so no transfer can complete then.
module risc_v_fetch_stage #(
    parameter logic [9:0]  RESET_PC   = 10'd0,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_rd_en,
    output logic [9:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_i,
    input  logic [9:0]  redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        illegal_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int CMT_W = CNT_W + 1;

    // Opcodes the decoder understands; anything else is flagged illegal.
    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_I_LOAD = 7'b0000011,
        OP_I_JALR = 7'b1100111,
        OP_I_ENV  = 7'b1110011,
        OP_S      = 7'b0100011,
        OP_B      = 7'b1100011,
        OP_J      = 7'b1101111,
        OP_U_LUI  = 7'b0110111,
        OP_U_AUI  = 7'b0010111
    } t_instr_opcode;

    logic [9:0]       pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [9:0]       inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      buf_instr_q [FIFO_DEPTH];
    logic [9:0]       buf_pc_q    [FIFO_DEPTH];

    logic             fifo_empty;
    logic             pop, push, issue;
    logic [CMT_W-1:0] committed;
    logic [31:0]      head_instr;
    logic [9:0]       head_pc;
    logic             head_legal;

    // Handshake events and credit check: buffered + in flight - leaving must
    // leave room for one more response, so the FIFO can never overflow.
    always_comb begin
        fifo_empty = (count_q == '0);
        head_instr = buf_instr_q[rd_ptr_q];
        head_pc    = buf_pc_q[rd_ptr_q];
        pop        = !fifo_empty && instr_ready_i && !redirect_i;
        push       = inflight_q && !redirect_i;
        committed  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}
                   - {{CNT_W{1'b0}}, pop};
        issue      = !rst && !redirect_i && (committed < CMT_W'(FIFO_DEPTH));
    end

    // Opcode membership of the head instruction.
    always_comb begin
        head_legal = 1'b0;
        case (head_instr[6:0])
            OP_R, OP_I, OP_I_LOAD, OP_I_JALR, OP_I_ENV,
            OP_S, OP_B, OP_J, OP_U_LUI, OP_U_AUI: head_legal = 1'b1;
            default:                              head_legal = 1'b0;
        endcase
    end

    // Outputs toward memory and decode; empty buffer shows a NOP at PC 0.
    always_comb begin
        imem_rd_en    = issue;
        imem_addr     = pc_q;
        instr_valid_o = !fifo_empty && !redirect_i;
        instr_o       = fifo_empty ? NOP_INSTR : head_instr;
        pc_o          = fifo_empty ? 32'd0 : {22'b0, head_pc, 2'b00};
        illegal_o     = instr_valid_o && !head_legal;
    end

    // Next state: a redirect flushes everything and wins over issue/push/pop.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (redirect_i) begin
            pc_d     = redirect_pc_i;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + 10'd1;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Buffer storage; contents are only visible while count says so.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr_q[wr_ptr_q] <= imem_rdata;
            buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_risc_v_fetch_stage.sv
// Bench for the fetch stage: directed latency/backpressure/redirect/reset
// sequences, a table of opcode vectors, and a randomized run checked
// against an expected-PC stream model.
module tb_risc_v_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic        imem_rd_en, imem_rd_en2;
    logic [9:0]  imem_addr, imem_addr2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic        redirect, redirect2;
    logic [9:0]  redirect_pc, redirect_pc2;
    logic        valid, valid2;
    logic        ready, ready2;
    logic [31:0] instr, instr2;
    logic [31:0] pc, pc2;
    logic        illegal, illegal2;

    logic [31:0] mem [1024];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] word;
        logic        exp_illegal;
    } vec_t;
    vec_t vecs[13];

    risc_v_fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .instr_valid_o(valid), .instr_ready_i(ready),
        .instr_o(instr), .pc_o(pc), .illegal_o(illegal)
    );

    risc_v_fetch_stage #(.RESET_PC(10'd1022)) dut2 (
        .clk(clk), .rst(rst2),
        .imem_rd_en(imem_rd_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
        .instr_valid_o(valid2), .instr_ready_i(ready2),
        .instr_o(instr2), .pc_o(pc2), .illegal_o(illegal2)
    );

    // Clock
    always #5 clk = ~clk;

    // Synchronous instruction memory: data the cycle after the strobe.
    always @(posedge clk) begin
        if (imem_rd_en)  imem_rdata  <= mem[imem_addr];
        if (imem_rd_en2) imem_rdata2 <= mem[imem_addr2];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic model_legal(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        return op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h73,
                          7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};
    endfunction

    function automatic logic [31:0] byte_pc(input logic [9:0] wpc);
        return {22'b0, wpc, 2'b00};
    endfunction

    task automatic wait_valid(input string name, input int bound);
        int k;
        k = 0;
        @(negedge clk);
        while (!valid && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk(name, valid, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_rd_en"},   imem_rd_en, 1'b0);
        chk({name, "_addr"},    imem_addr,  32'd0);
        chk({name, "_valid"},   valid,      1'b0);
        chk({name, "_instr"},   instr,      NOP);
        chk({name, "_pc"},      pc,         32'd0);
        chk({name, "_illegal"}, illegal,    1'b0);
    endtask

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0]  legal_ops [10];
        logic [31:0] w;
        logic [9:0]  exp_pc;
        logic        prev_stall;
        logic [31:0] prev_pc, prev_instr;
        int          rd_cnt, pops;

        legal_ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            if ($urandom_range(0, 4) != 0) w[6:0] = legal_ops[$urandom_range(0, 9)];
            mem[i] = w;
        end
        mem[0] = 32'h0010_0093;
        mem[1] = 32'h0020_0113;
        mem[2] = 32'h0030_0193;
        mem[3] = 32'h0040_0213;

        vecs[0]  = '{32'h0000_0033, 1'b0};
        vecs[1]  = '{32'h0000_0013, 1'b0};
        vecs[2]  = '{32'h0000_2003, 1'b0};
        vecs[3]  = '{32'h0000_0067, 1'b0};
        vecs[4]  = '{32'h0000_0073, 1'b0};
        vecs[5]  = '{32'h0000_2023, 1'b0};
        vecs[6]  = '{32'h0000_0063, 1'b0};
        vecs[7]  = '{32'h0000_006F, 1'b0};
        vecs[8]  = '{32'h1234_5037, 1'b0};
        vecs[9]  = '{32'h1234_5017, 1'b0};
        vecs[10] = '{32'h0000_007F, 1'b1};
        vecs[11] = '{32'h0000_0000, 1'b1};
        vecs[12] = '{32'hFFFF_F00B, 1'b1};
        for (int i = 0; i < 13; i++) mem[500 + i] = vecs[i].word;

        // Reset block
        rst = 1'b1; rst2 = 1'b1;
        ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        ready2 = 1'b1; redirect2 = 1'b0; redirect_pc2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");

        // Reset release and first-fetch latency
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t1_c0_rd_en", imem_rd_en, 1'b1);
        chk("t1_c0_addr", imem_addr, 32'd0);
        chk("t1_c0_valid", valid, 1'b0);
        @(negedge clk);
        chk("t1_c1_valid", valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_valid", valid, 1'b1);
            chk("t1_pc", pc, 32'(i * 4));
            chk("t1_instr", instr, mem[i]);
            chk("t1_illegal", illegal, 1'b0);
        end

        // Backpressure: only FIFO_DEPTH reads, head held stable
        rst = 1'b1; ready = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        rd_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (imem_rd_en) rd_cnt++;
            if (c >= 2) begin
                chk("t2_hold_valid", valid, 1'b1);
                chk("t2_hold_pc", pc, 32'd0);
                chk("t2_hold_instr", instr, mem[0]);
            end
        end
        chk("t2_read_count", 32'(rd_cnt), 32'd2);
        chk("t2_rd_en_low", imem_rd_en, 1'b0);
        @(posedge clk); #1 ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_drain_valid", valid, 1'b1);
            chk("t2_drain_pc", pc, 32'(i * 4));
            chk("t2_drain_instr", instr, mem[i]);
        end

        // Redirect while streaming (one buffered, one in flight)
        @(posedge clk); #1 redirect = 1'b1; redirect_pc = 10'd40;
        @(negedge clk);
        chk("t3_redir_valid", valid, 1'b0);
        chk("t3_redir_rd_en", imem_rd_en, 1'b0);
        @(posedge clk); #1 redirect = 1'b0;
        @(negedge clk);
        chk("t3_rd_en", imem_rd_en, 1'b1);
        chk("t3_addr", imem_addr, 32'd40);
        chk("t3_valid_c1", valid, 1'b0);
        @(negedge clk);
        chk("t3_valid_c2", valid, 1'b0);
        @(negedge clk);
        chk("t3_valid", valid, 1'b1);
        chk("t3_pc", pc, 32'd160);
        chk("t3_instr", instr, mem[40]);
        @(negedge clk);
        chk("t3_pc_next", pc, 32'd164);

        // Back-to-back redirects with a full FIFO: last wins
        @(posedge clk); #1 ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 redirect = 1'b1; redirect_pc = 10'd100;
        @(posedge clk); #1 redirect_pc = 10'd200;
        @(negedge clk);
        chk("t3b_valid", valid, 1'b0);
        @(posedge clk); #1 redirect = 1'b0; ready = 1'b1;
        @(negedge clk);
        chk("t3b_addr", imem_addr, 32'd200);
        chk("t3b_valid_c1", valid, 1'b0);
        @(negedge clk);
        chk("t3b_valid_c2", valid, 1'b0);
        @(negedge clk);
        chk("t3b_pc", pc, 32'd800);
        chk("t3b_instr", instr, mem[200]);

        // Opcode vector table
        @(posedge clk); #1 ready = 1'b0; redirect = 1'b1; redirect_pc = 10'd500;
        @(posedge clk); #1 redirect = 1'b0;
        for (int i = 0; i < 13; i++) begin
            wait_valid("t5_wait", 10);
            chk("t5_pc", pc, byte_pc(10'(500 + i)));
            chk("t5_instr", instr, vecs[i].word);
            chk("t5_illegal", illegal, vecs[i].exp_illegal);
            @(posedge clk); #1 ready = 1'b1;
            @(posedge clk); #1 ready = 1'b0;
        end

        // Randomized run against an expected-PC stream model
        exp_pc = '0; prev_stall = 1'b0; prev_pc = '0; prev_instr = '0; pops = 0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            ready       = ($urandom_range(0, 3) != 0);
            redirect    = (n == 0) || ($urandom_range(0, 31) == 0);
            redirect_pc = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 15) == 0) redirect_pc = 10'($urandom_range(1020, 1023));
            @(negedge clk);
            if (redirect) begin
                chk("rand_redir_valid", valid, 1'b0);
                chk("rand_redir_rd_en", imem_rd_en, 1'b0);
                exp_pc = redirect_pc;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("rand_hold_valid", valid, 1'b1);
                    chk("rand_hold_pc", pc, prev_pc);
                    chk("rand_hold_instr", instr, prev_instr);
                end
                if (valid) begin
                    chk("rand_pc", pc, byte_pc(exp_pc));
                    chk("rand_instr", instr, mem[exp_pc]);
                    chk("rand_illegal", illegal, !model_legal(mem[exp_pc]));
                    if (ready) begin
                        exp_pc = exp_pc + 10'd1;
                        pops++;
                    end
                end else begin
                    chk("rand_empty_instr", instr, NOP);
                    chk("rand_empty_pc", pc, 32'd0);
                    chk("rand_empty_illegal", illegal, 1'b0);
                end
                prev_stall = valid && !ready;
                prev_pc    = pc;
                prev_instr = instr;
            end
        end
        chk("rand_progress", 32'(pops > 400), 32'd1);

        // Asynchronous reset mid-stream
        @(posedge clk); #1 redirect = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1 ready = 1'($urandom_range(0, 1));
        end
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("t6_async");
        @(posedge clk); #1 rst = 1'b0; ready = 1'b1;
        @(negedge clk);
        chk("t6_rd_en", imem_rd_en, 1'b1);
        chk("t6_addr", imem_addr, 32'd0);
        @(negedge clk);
        chk("t6_valid_c1", valid, 1'b0);
        @(negedge clk);
        chk("t6_valid", valid, 1'b1);
        chk("t6_pc0", pc, 32'd0);
        chk("t6_instr0", instr, mem[0]);
        @(negedge clk);
        chk("t6_pc1", pc, 32'd4);

        // PC wrap from RESET_PC=1022 on the second instance
        @(negedge clk);
        chk("t4_rst_addr", imem_addr2, 32'd1022);
        chk("t4_rst_valid", valid2, 1'b0);
        chk("t4_rst_pc", pc2, 32'd0);
        @(posedge clk); #1 rst2 = 1'b0;
        @(negedge clk);
        chk("t4_rd_en", imem_rd_en2, 1'b1);
        @(negedge clk);
        chk("t4_valid_c1", valid2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_valid", valid2, 1'b1);
            chk("t4_pc", pc2, byte_pc(10'(1022 + i)));
            chk("t4_instr", instr2, mem[10'(1022 + i)]);
            chk("t4_illegal", illegal2, !model_legal(mem[10'(1022 + i)]));
        end

        // Report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
